// File: rtl/scene_pkg.sv
// scene_pkg: geometry and colour constants for the playfield.
// The game logic and the renderer both take their geometry from here.
// Holds: block grid (64x16 px, 12x6), tile size, wall/ceiling/paddle/ball
// placement, the per-row block colours and the fixed object colours.
package scene_pkg;

    localparam int unsigned BLOCK_W_PIXEL   = 64;
    localparam int unsigned BLOCK_H_PIXEL   = 16;
    localparam int unsigned TILE_PIXEL      = 8;
    localparam int unsigned BLOCK_COLS      = 12;
    localparam int unsigned BLOCK_ROWS      = 6;
    localparam int unsigned BLOCK_COUNT     = BLOCK_COLS * BLOCK_ROWS;

    localparam int unsigned BLOCK_START_X_PIXEL = 16;
    localparam int unsigned BLOCK_START_Y_PIXEL = 64;
    localparam int unsigned WALL_LEFT_X_PIXEL   = 8;
    localparam int unsigned WALL_RIGHT_X_PIXEL  = 784;
    localparam int unsigned WALL_W_PIXEL        = 8;
    localparam int unsigned CEILING_Y_PIXEL     = 8;
    localparam int unsigned CEILING_H_PIXEL     = 8;
    localparam int unsigned PADDLE_Y_PIXEL      = 560;
    localparam int unsigned PADDLE_H_PIXEL      = 8;
    localparam int unsigned PADDLE_LENGTH_PIXEL = 60;
    localparam int unsigned BALL_SIZE_PIXEL     = 8;

    localparam logic [7:0] COLOUR_BALL   = 8'hFF;
    localparam logic [7:0] COLOUR_PADDLE = 8'h1F;
    localparam logic [7:0] COLOUR_WALL   = 8'h92;
    localparam logic [7:0] COLOUR_BG     = 8'h00;
    localparam logic [7:0] COLOUR_GRID   = 8'h49;

    // Row colours, top row first.
    function automatic logic [7:0] row_colour(input logic [2:0] row);
        logic [7:0] c;
        case (row)
            3'd0:    c = 8'hE0;
            3'd1:    c = 8'hEC;
            3'd2:    c = 8'hFC;
            3'd3:    c = 8'h1C;
            3'd4:    c = 8'h13;
            3'd5:    c = 8'h03;
            default: c = COLOUR_BG;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/scene_block_lookup.sv
// scene_block_lookup: combinational block presence and colour lookup.
// Ports:
//   row_i      block row (0..5) from stage 1
//   col_i      block column (0..11) from stage 1
//   in_area_i  pixel lies inside the block grid
//   blocks_i   snapshot block vector, bit = row*12 + col
//   present_o  block at row/col exists (0 outside the grid)
//   colour_o   colour of that block row
module scene_block_lookup
    import scene_pkg::*;
(
    input  logic [2:0]             row_i,
    input  logic [3:0]             col_i,
    input  logic                   in_area_i,
    input  logic [BLOCK_COUNT-1:0] blocks_i,
    output logic                   present_o,
    output logic [7:0]             colour_o
);

    logic [6:0] idx;

    always_comb begin
        idx       = 7'd0;
        present_o = 1'b0;
        // The index is only formed inside the grid, so it stays within 0..71.
        if (in_area_i) begin
            idx       = ({4'd0, row_i} * 7'(BLOCK_COLS)) + {3'd0, col_i};
            present_o = blocks_i[idx];
        end
        colour_o = row_colour(row_i);
    end

endmodule

// File: rtl/scene_renderer.sv
// scene_renderer: per-pixel RGB332 generator for the 800x600 playfield.
// Snapshots paddle, ball and block state on FRAME_SYNC, then renders each
// pixel through a 2-stage pipeline (hit tests, then colour priority).
// Ports:
//   CLK, RESET (synchronous, active-high)
//   FRAME_SYNC       one-cycle snapshot strobe (start of vertical blank)
//   PIXEL_X/Y        current pixel coordinate, PIXEL_ACTIVE visible flag
//   PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, BLOCK_STATE  game state
//   RGB              RGB332 colour, 2 cycles after the coordinate
//   RGB_VALID        PIXEL_ACTIVE aligned with RGB
// Build option: define RENDER_DEBUG_GRID_EN to draw a dim 8-px tile grid on
// the background.
module scene_renderer
    import scene_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   FRAME_SYNC,
    input  logic [9:0]             PIXEL_X,
    input  logic [9:0]             PIXEL_Y,
    input  logic                   PIXEL_ACTIVE,
    input  logic [9:0]             PADDLE_X_PIXEL,
    input  logic [9:0]             BALL_X_PIXEL,
    input  logic [9:0]             BALL_Y_PIXEL,
    input  logic [BLOCK_COUNT-1:0] BLOCK_STATE,
    output logic [7:0]             RGB,
    output logic                   RGB_VALID
);

    // Frame snapshot
    logic [9:0]             paddle_x_q, ball_x_q, ball_y_q;
    logic [BLOCK_COUNT-1:0] blocks_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            paddle_x_q <= '0;
            ball_x_q   <= '0;
            ball_y_q   <= '0;
            blocks_q   <= '0;
        end else if (FRAME_SYNC) begin
            paddle_x_q <= PADDLE_X_PIXEL;
            ball_x_q   <= BALL_X_PIXEL;
            ball_y_q   <= BALL_Y_PIXEL;
            blocks_q   <= BLOCK_STATE;
        end
    end

    // Stage 1: hit tests. All compares are 11 bits wide so object extents
    // near x/y = 1023 do not wrap.
    logic [10:0] x_ext, y_ext, dx, dy;
    logic [10:0] ball_x_ext, ball_y_ext, paddle_x_ext;
    logic        in_area_d, mortar_d, ball_d, paddle_d, wall_d;
    logic        left_d, right_d, ceiling_d;

    always_comb begin
        x_ext        = {1'b0, PIXEL_X};
        y_ext        = {1'b0, PIXEL_Y};
        ball_x_ext   = {1'b0, ball_x_q};
        ball_y_ext   = {1'b0, ball_y_q};
        paddle_x_ext = {1'b0, paddle_x_q};

        // dx/dy are two's complement; bit 10 set means left of / above the grid.
        dx = x_ext - 11'(BLOCK_START_X_PIXEL);
        dy = y_ext - 11'(BLOCK_START_Y_PIXEL);

        in_area_d = !dx[10] && !dy[10]
                    && (dx[9:6] < 4'(BLOCK_COLS))
                    && (dy[9:4] < 6'(BLOCK_ROWS));
        mortar_d  = (dx[5:0] == 6'd0) || (dy[3:0] == 4'd0);

        ball_d = (x_ext >= ball_x_ext) && (x_ext < ball_x_ext + 11'(BALL_SIZE_PIXEL))
              && (y_ext >= ball_y_ext) && (y_ext < ball_y_ext + 11'(BALL_SIZE_PIXEL));

        paddle_d = (x_ext >= paddle_x_ext)
                && (x_ext < paddle_x_ext + 11'(PADDLE_LENGTH_PIXEL))
                && (y_ext >= 11'(PADDLE_Y_PIXEL))
                && (y_ext < 11'(PADDLE_Y_PIXEL + PADDLE_H_PIXEL));

        // Side walls run from the ceiling down to the bottom of the screen.
        left_d  = (x_ext >= 11'(WALL_LEFT_X_PIXEL))
               && (x_ext < 11'(WALL_LEFT_X_PIXEL + WALL_W_PIXEL));
        right_d = (x_ext >= 11'(WALL_RIGHT_X_PIXEL))
               && (x_ext < 11'(WALL_RIGHT_X_PIXEL + WALL_W_PIXEL));
        ceiling_d = (y_ext >= 11'(CEILING_Y_PIXEL))
                 && (y_ext < 11'(CEILING_Y_PIXEL + CEILING_H_PIXEL))
                 && (x_ext >= 11'(WALL_LEFT_X_PIXEL))
                 && (x_ext < 11'(WALL_RIGHT_X_PIXEL + WALL_W_PIXEL));
        wall_d = ceiling_d || ((left_d || right_d) && (y_ext >= 11'(CEILING_Y_PIXEL)));
    end

    logic       s1_active_q, s1_in_area_q, s1_mortar_q;
    logic       s1_ball_q, s1_paddle_q, s1_wall_q;
    logic [2:0] s1_row_q;
    logic [3:0] s1_col_q;
`ifdef RENDER_DEBUG_GRID_EN
    logic       s1_grid_q;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_active_q  <= 1'b0;
            s1_in_area_q <= 1'b0;
            s1_mortar_q  <= 1'b0;
            s1_ball_q    <= 1'b0;
            s1_paddle_q  <= 1'b0;
            s1_wall_q    <= 1'b0;
            s1_row_q     <= '0;
            s1_col_q     <= '0;
`ifdef RENDER_DEBUG_GRID_EN
            s1_grid_q    <= 1'b0;
`endif
        end else begin
            s1_active_q  <= PIXEL_ACTIVE;
            s1_in_area_q <= in_area_d;
            s1_mortar_q  <= mortar_d;
            s1_ball_q    <= ball_d;
            s1_paddle_q  <= paddle_d;
            s1_wall_q    <= wall_d;
            s1_row_q     <= dy[6:4];
            s1_col_q     <= dx[9:6];
`ifdef RENDER_DEBUG_GRID_EN
            s1_grid_q    <= (PIXEL_X[2:0] == 3'd0) || (PIXEL_Y[2:0] == 3'd0);
`endif
        end
    end

    // Stage 2: block lookup and colour priority.
    logic       block_present;
    logic [7:0] block_colour;

    scene_block_lookup u_block_lookup (
        .row_i     (s1_row_q),
        .col_i     (s1_col_q),
        .in_area_i (s1_in_area_q),
        .blocks_i  (blocks_q),
        .present_o (block_present),
        .colour_o  (block_colour)
    );

    logic [7:0] rgb_d;
    logic [7:0] rgb_q;
    logic       rgb_valid_q;

    always_comb begin
        rgb_d = COLOUR_BG;
        if (!s1_active_q) begin
            rgb_d = COLOUR_BG;
        end else if (s1_ball_q) begin
            rgb_d = COLOUR_BALL;
        end else if (s1_paddle_q) begin
            rgb_d = COLOUR_PADDLE;
        end else if (s1_wall_q) begin
            rgb_d = COLOUR_WALL;
        end else if (block_present && !s1_mortar_q) begin
            rgb_d = block_colour;
`ifdef RENDER_DEBUG_GRID_EN
        end else if (s1_grid_q) begin
            rgb_d = COLOUR_GRID;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            rgb_valid_q <= s1_active_q;
        end
    end

    assign RGB       = rgb_q;
    assign RGB_VALID = rgb_valid_q;

endmodule

// File: tb/tb_scene_renderer.sv
module tb_scene_renderer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FRAME_SYNC;
    logic [9:0]  PIXEL_X, PIXEL_Y;
    logic        PIXEL_ACTIVE;
    logic [9:0]  PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL;
    logic [71:0] BLOCK_STATE;
    logic [7:0]  RGB;
    logic        RGB_VALID;

    scene_renderer dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .FRAME_SYNC     (FRAME_SYNC),
        .PIXEL_X        (PIXEL_X),
        .PIXEL_Y        (PIXEL_Y),
        .PIXEL_ACTIVE   (PIXEL_ACTIVE),
        .PADDLE_X_PIXEL (PADDLE_X_PIXEL),
        .BALL_X_PIXEL   (BALL_X_PIXEL),
        .BALL_Y_PIXEL   (BALL_Y_PIXEL),
        .BLOCK_STATE    (BLOCK_STATE),
        .RGB            (RGB),
        .RGB_VALID      (RGB_VALID)
    );

    always #5 CLK = ~CLK;

`ifdef RENDER_DEBUG_GRID_EN
    localparam bit GRID_EN = 1'b1;
`else
    localparam bit GRID_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [9:0]  pad, bx, by;
        logic [71:0] blocks;
        logic [9:0]  x, y;
        logic        act;
        logic        bg;    // expected colour is background at (x,y)
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        logic       fs;
        logic [9:0] bx, x, y;
        logic       bg;
        logic [7:0] exp;
    } step_t;

    vec_t  vecs[$];
    step_t steps[$];

    function automatic logic [7:0] bg_exp(input logic [9:0] x, input logic [9:0] y);
        return (GRID_EN && ((x[2:0] == 3'd0) || (y[2:0] == 3'd0))) ? 8'h49 : 8'h00;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic add(input logic [9:0] pad, input logic [9:0] bx, input logic [9:0] by,
                       input logic [71:0] blocks, input logic [9:0] x, input logic [9:0] y,
                       input logic act, input logic bg, input logic [7:0] exp);
        vec_t v;
        v.pad = pad; v.bx = bx; v.by = by; v.blocks = blocks;
        v.x = x; v.y = y; v.act = act; v.bg = bg; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic add_step(input logic fs, input logic [9:0] bx, input logic [9:0] x,
                            input logic [9:0] y, input logic bg, input logic [7:0] exp);
        step_t s;
        s.fs = fs; s.bx = bx; s.x = x; s.y = y; s.bg = bg; s.exp = exp;
        steps.push_back(s);
    endtask

    logic [71:0] all_on, no13;
    logic [7:0]  e;

    initial begin
        all_on = '1;
        no13   = '1;
        no13[13] = 1'b0;

        //  pad  bx    by   blocks   x     y    act bg exp
        add(370, 395,  400, all_on,  17,   65,  1, 0, 8'hE0);  // row 0 col 0
        add(370, 395,  400, all_on,  16,   65,  1, 1, 8'h00);  // vertical mortar
        add(370, 395,  400, all_on,  17,   64,  1, 1, 8'h00);  // horizontal mortar
        add(370, 395,  400, all_on,  721,  145, 1, 0, 8'h03);  // row 5 col 11
        add(370, 395,  400, all_on,  300,  97,  1, 0, 8'hFC);  // row 2
        add(370, 395,  400, all_on,  300,  113, 1, 0, 8'h1C);  // row 3
        add(370, 395,  400, all_on,  300,  129, 1, 0, 8'h13);  // row 4
        add(370, 395,  400, all_on,  17,   161, 1, 1, 8'h00);  // below the grid
        add(370, 395,  400, all_on,  784,  65,  1, 0, 8'h92);  // col 12 is right wall
        add(370, 395,  400, no13,    81,   81,  1, 1, 8'h00);  // cleared block 13
        add(370, 395,  400, no13,    145,  81,  1, 0, 8'hEC);  // neighbour still there
        add(370, 395,  400, all_on,  402,  407, 1, 0, 8'hFF);  // ball bottom-right
        add(370, 395,  400, all_on,  403,  400, 1, 1, 8'h00);  // just right of ball
        add(370, 1020, 0,   all_on,  1023, 0,   1, 0, 8'hFF);  // ball at right edge
        add(370, 1020, 0,   all_on,  0,    0,   1, 1, 8'h00);  // no wrap to x=0
        add(370, 400,  560, all_on,  400,  560, 1, 0, 8'hFF);  // ball over paddle
        add(370, 400,  560, all_on,  429,  567, 1, 0, 8'h1F);  // paddle last px
        add(370, 400,  560, all_on,  430,  560, 1, 1, 8'h00);  // past paddle
        add(370, 395,  400, all_on,  8,    300, 1, 0, 8'h92);  // left wall
        add(370, 395,  400, all_on,  791,  100, 1, 0, 8'h92);  // right wall
        add(370, 395,  400, all_on,  400,  8,   1, 0, 8'h92);  // ceiling
        add(370, 395,  400, all_on,  792,  8,   1, 1, 8'h00);  // past ceiling end
        add(370, 395,  400, all_on,  17,   65,  0, 0, 8'h00);  // inactive block px
        add(370, 395,  400, all_on,  402,  407, 0, 0, 8'h00);  // inactive ball px

        RESET = 1'b1; FRAME_SYNC = 1'b0;
        PIXEL_X = 10'd3; PIXEL_Y = 10'd3; PIXEL_ACTIVE = 1'b1;
        PADDLE_X_PIXEL = 10'd370; BALL_X_PIXEL = 10'd395; BALL_Y_PIXEL = 10'd400;
        BLOCK_STATE = all_on;

        // Reset for 3 cycles with an active pixel sitting on the reset-time ball (0,0).
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_rgb%0d", i), RGB, 8'h00);
            check($sformatf("reset_valid%0d", i), {7'd0, RGB_VALID}, 8'h00);
        end
        RESET = 1'b0;
        check("post_reset0_rgb", RGB, 8'h00);
        check("post_reset0_valid", {7'd0, RGB_VALID}, 8'h00);
        tick();
        check("post_reset1_rgb", RGB, 8'h00);
        check("post_reset1_valid", {7'd0, RGB_VALID}, 8'h00);
        tick();
        check("post_reset2_rgb", RGB, 8'hFF);
        check("post_reset2_valid", {7'd0, RGB_VALID}, 8'h01);

        // Table: snapshot, present the pixel, read it 2 cycles later.
        for (int i = 0; i < vecs.size(); i++) begin
            PADDLE_X_PIXEL = vecs[i].pad;
            BALL_X_PIXEL   = vecs[i].bx;
            BALL_Y_PIXEL   = vecs[i].by;
            BLOCK_STATE    = vecs[i].blocks;
            FRAME_SYNC     = 1'b1;
            PIXEL_ACTIVE   = 1'b0;
            tick();
            FRAME_SYNC   = 1'b0;
            PIXEL_X      = vecs[i].x;
            PIXEL_Y      = vecs[i].y;
            PIXEL_ACTIVE = vecs[i].act;
            tick();
            PIXEL_ACTIVE = 1'b0;
            tick();
            e = vecs[i].bg ? bg_exp(vecs[i].x, vecs[i].y) : vecs[i].exp;
            check($sformatf("vec%0d_rgb", i), RGB, e);
            check($sformatf("vec%0d_valid", i), {7'd0, RGB_VALID}, {7'd0, vecs[i].act});
        end

        // Streaming sequence: one pixel per cycle, FRAME_SYNC mid-line,
        // input changes without FRAME_SYNC, and back-to-back FRAME_SYNC.
        BALL_Y_PIXEL = 10'd400;
        //       fs  bx   x    y    bg exp
        add_step(1, 395, 0,   0,   1, 8'h00);  // snapshot ball at 395
        add_step(1, 500, 402, 400, 0, 8'hFF);  // same-cycle pixel uses old ball
        add_step(0, 500, 402, 400, 1, 8'h00);  // next cycle uses new ball
        add_step(0, 500, 505, 400, 0, 8'hFF);
        add_step(0, 0,   505, 407, 0, 8'hFF);  // input moved, no snapshot
        add_step(0, 0,   3,   403, 1, 8'h00);
        add_step(1, 100, 0,   0,   1, 8'h00);  // back-to-back: 100 then 200
        add_step(1, 200, 0,   0,   1, 8'h00);
        add_step(0, 100, 103, 403, 1, 8'h00);
        add_step(0, 100, 203, 403, 0, 8'hFF);
        PIXEL_ACTIVE = 1'b1;
        for (int i = 0; i <= steps.size(); i++) begin
            if (i < steps.size()) begin
                FRAME_SYNC   = steps[i].fs;
                BALL_X_PIXEL = steps[i].bx;
                PIXEL_X      = steps[i].x;
                PIXEL_Y      = steps[i].y;
                PIXEL_ACTIVE = 1'b1;
            end else begin
                FRAME_SYNC   = 1'b0;
                PIXEL_ACTIVE = 1'b0;
            end
            tick();
            if (i >= 1) begin
                e = steps[i-1].bg ? bg_exp(steps[i-1].x, steps[i-1].y) : steps[i-1].exp;
                check($sformatf("step%0d_rgb", i - 1), RGB, e);
                check($sformatf("step%0d_valid", i - 1), {7'd0, RGB_VALID}, 8'h01);
            end
        end

        // Reset mid-frame clears the pipeline and the snapshot.
        PIXEL_X = 10'd203; PIXEL_Y = 10'd403; PIXEL_ACTIVE = 1'b1;
        tick();
        RESET = 1'b1;
        tick();
        check("midreset_rgb", RGB, 8'h00);
        check("midreset_valid", {7'd0, RGB_VALID}, 8'h00);
        RESET = 1'b0;
        PIXEL_ACTIVE = 1'b0;
        tick();
        check("midreset_flush_rgb", RGB, 8'h00);
        check("midreset_flush_valid", {7'd0, RGB_VALID}, 8'h00);
        // Snapshot now zero: pixel (203,403) is background, ball sits at (0,0).
        PIXEL_ACTIVE = 1'b1;
        tick();
        PIXEL_X = 10'd7; PIXEL_Y = 10'd7;
        tick();
        check("midreset_old_ball_gone", RGB, bg_exp(10'd203, 10'd403));
        PIXEL_ACTIVE = 1'b0;
        tick();
        check("midreset_ball_at_zero", RGB, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
